// File: rtl/add_sub_pipe.sv
// Pipelined N-bit adder/subtractor: the carry chain is cut into STAGES slices of
// N/STAGES bits with a register after each slice, under a single global advance.
`timescale 1ns/1ps
module add_sub_pipe #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    localparam int W = N / STAGES;

    logic         w_adv;
    logic [N-1:0] w_beff;
    logic         w_c0;

    // Subtract is a + ~b + ~cin; the borrow is the inverted carry at the end.
    assign w_beff   = sub ? ~b : b;
    assign w_c0     = sub ? ~cin : cin;
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * W;

        // Operand bits not yet consumed enter at the bottom of w_a_in/w_b_in.
        logic [N-LO-1:0] w_a_in;
        logic [N-LO-1:0] w_b_in;
        logic            w_c_in;
        logic            w_sub_in;
        logic            w_vld_in;
        logic [W:0]      w_slice;
        logic [LO+W-1:0] w_sum_nxt;
        logic            r_vld;
        logic [LO+W-1:0] r_sum;

        if (k == 0) begin : g_src
            assign w_a_in    = a;
            assign w_b_in    = w_beff;
            assign w_c_in    = w_c0;
            assign w_sub_in  = sub;
            assign w_vld_in  = in_valid;
            assign w_sum_nxt = w_slice[W-1:0];
        end else begin : g_src
            assign w_a_in    = g_stage[k-1].g_fwd.r_a;
            assign w_b_in    = g_stage[k-1].g_fwd.r_b;
            assign w_c_in    = g_stage[k-1].g_fwd.r_c;
            assign w_sub_in  = g_stage[k-1].g_fwd.r_sub;
            assign w_vld_in  = g_stage[k-1].r_vld;
            assign w_sum_nxt = {w_slice[W-1:0], g_stage[k-1].r_sum};
        end

        assign w_slice = {1'b0, w_a_in[W-1:0]} + {1'b0, w_b_in[W-1:0]} + {{W{1'b0}}, w_c_in};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_sum <= '0;
            end else if (w_adv) begin
                r_vld <= w_vld_in;
                r_sum <= w_sum_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [N-LO-W-1:0] r_a;
            logic [N-LO-W-1:0] r_b;
            logic              r_c;
            logic              r_sub;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_c   <= 1'b0;
                    r_sub <= 1'b0;
                end else if (w_adv) begin
                    r_a   <= w_a_in[N-LO-1:W];
                    r_b   <= w_b_in[N-LO-1:W];
                    r_c   <= w_slice[W];
                    r_sub <= w_sub_in;
                end
            end
        end else begin : g_last
            logic r_cout;
            logic r_ovf;

            // The top slice still holds both operand sign bits, so ovf resolves here.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cout <= 1'b0;
                    r_ovf  <= 1'b0;
                end else if (w_adv) begin
                    r_cout <= w_sub_in ? ~w_slice[W] : w_slice[W];
                    r_ovf  <= (w_a_in[W-1] == w_b_in[W-1]) && (w_slice[W-1] != w_a_in[W-1]);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_vld;
    assign sum       = g_stage[STAGES-1].r_sum;
    assign cout      = g_stage[STAGES-1].g_last.r_cout;
    assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule

// File: doc/add_sub_pipe.md
# add_sub_pipe

Parametrised, pipelined N-bit adder/subtractor with valid/ready flow control, add/subtract mode, carry/borrow out and signed-overflow flag. It is the next generation of the team's registered N-bit full adder: the carry chain is split into STAGES equal slices with a register between slices, so wide operands close timing at high clock rates. It sits between operand producers and result consumers in datapath pipelines and accepts one operation per cycle when not stalled.

## Interface
- N, 32, operand/result width in bits; N >= 1.
- STAGES, 4, pipeline depth and number of carry-chain slices; 1 <= STAGES <= N, N % STAGES == 0; slice width W = N/STAGES.
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation presented on a, b, cin, sub.
- in_ready  output  1  block accepts the operation this cycle.
- a  input  N  operand A (unsigned or two's complement).
- b  input  N  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  sum/cout/ovf hold a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- sum  output  N  result, modulo 2^N.
- cout  output  1  add: carry out of bit N-1; sub: borrow out (1 when a < b + cin, unsigned).
- ovf  output  1  signed two's-complement overflow of the operation.

## Operation
- Arithmetic: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin; raw = a + b_eff + c0 (N+1 bits). sum = raw[N-1:0]; cout = sub ? ~raw[N] : raw[N]; ovf = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]).
- Add: sum = a + b + cin. Sub: sum = a - b - cin.
- Stage k (0..STAGES-1) computes slice bits [k*W +: W] using carry from stage k-1 (stage 0 uses c0). Finished lower slices and not-yet-used upper operand slices (a, b_eff) ride forward in skew registers; sign bits needed for ovf travel with them.
- Each stage holds a valid bit. Global advance = ~out_valid | out_ready; in_ready = advance. On an edge with advance=1, every stage loads from its predecessor; stage 0 loads the input operation with valid = in_valid. On advance=0 all stages hold.
- Bubbles (in_valid=0 on an advancing edge) travel as invalid slots; they are not collapsed.
- Results leave in strict acceptance order; no drop, no duplication.
- out_valid = valid bit of the last stage; sum/cout/ovf are driven directly from last-stage registers.
- Reset: all valid bits 0; sum = 0, cout = 0, ovf = 0, out_valid = 0; in_ready = 1 (combinational from advance). All skew/data registers clear to 0.

## Timing
- Acceptance: edge where in_valid && in_ready.
- Latency: result visible on outputs after STAGES rising edges counting the acceptance edge (STAGES=1: visible right after the acceptance edge, i.e. plain registered adder).
- Throughput: 1 op/cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 -> in_ready=0 same cycle; all stages and outputs hold stable until out_ready rises.
- Simultaneous consume and accept: out_valid && out_ready && in_valid -> both occur on the same edge.
- in_ready depends combinationally on out_valid and out_ready only; never on in_valid.
- rst asserted at any time, including mid-stream or mid-stall: all outputs go to reset values immediately, without a clock edge; in-flight operations are discarded. First acceptance possible on the first rising edge after rst deasserts.
- Wrap-around: sum wraps modulo 2^N; no saturation.

## Test plan
- Reset: drive rst=1 with the pipeline full -> out_valid=0, sum=0, cout=0, ovf=0 asynchronously; in_ready=1; after release no stale result appears.
- Add carry across all slices (N=32, STAGES=4): a=0xFFFFFFFF, b=0x00000000, cin=1, sub=0 -> sum=0x00000000, cout=1, ovf=0, out_valid exactly 4 edges after acceptance. Also a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0, ovf=1.
- Subtract: a=5, b=7, cin=0, sub=1 -> sum=0xFFFFFFFE, cout=1, ovf=0; a=0x80000000, b=1, cin=0 -> sum=0x7FFFFFFF, cout=0, ovf=1; a=10, b=3, cin=1 -> sum=6, cout=0.
- Streaming: 16 back-to-back random ops, out_ready=1 -> 16 results on consecutive cycles, in order, matching reference model; inserted bubbles appear as out_valid=0 in the same slots.
- Backpressure: pipeline full, out_ready=0 for 3 cycles -> in_ready=0, outputs constant; on out_ready=1 results resume one per cycle with no loss or duplication.
- Parameter sweep: (N=8, STAGES=1), (N=8, STAGES=8), (N=64, STAGES=4) -> exhaustive or random checks against raw-formula model; latency equals STAGES.
